// File: rtl/decode_issue.sv
// Decodes fetch words, reads the register file and presents a registered operand bundle one cycle after acceptance.
// Backpressure: a held bundle stalls fetch (if_ready=0) and its operands track register file writes; HALT also stalls fetch.
module decode_issue #(
  parameter int LEN_INSN    = 32,
  parameter int LEN_OPECODE = 7,
  parameter int LEN_IMMF    = 1,
  parameter int LEN_REG     = 32,
  parameter int LEN_CC      = 4,
  parameter int LEN_IMM_EX  = 32,
  parameter int LEN_REGNO   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [LEN_INSN-1:0]    if_insn,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [LEN_OPECODE-1:0] opecode,
  output logic [LEN_IMMF-1:0]    immf,
  output logic [LEN_REG-1:0]     data_rd,
  output logic [LEN_REG-1:0]     data_rs,
  output logic [LEN_CC-1:0]      cc,
  output logic [LEN_IMM_EX-1:0]  imm_ex,
  output logic [LEN_REGNO-1:0]   ex_rd_addr,
  output logic                   ex_wen,
  input  logic                   wb_we,
  input  logic [LEN_REGNO-1:0]   wb_addr,
  input  logic [LEN_REG-1:0]     wb_data,
  input  logic                   resume,
  output logic                   halted,
  output logic                   illegal
);

  localparam logic [LEN_OPECODE-1:0] OP_CMP  = 7'b0000100;
  localparam logic [LEN_OPECODE-1:0] OP_ST   = 7'b0011001;
  localparam logic [LEN_OPECODE-1:0] OP_J    = 7'b0011010;
  localparam logic [LEN_OPECODE-1:0] OP_JA   = 7'b0011011;
  localparam logic [LEN_OPECODE-1:0] OP_NOP  = 7'b1111110;
  localparam logic [LEN_OPECODE-1:0] OP_HLT  = 7'b1111111;

  typedef enum logic {RUN, HALT} state_t;

  state_t                 state;
  logic [LEN_REGNO-1:0]   ex_rs_addr;
  logic [LEN_REG-1:0]     regs [2**LEN_REGNO];

  logic [LEN_OPECODE-1:0] f_op;
  logic [LEN_IMMF-1:0]    f_immf;
  logic [LEN_REGNO-1:0]   f_rd;
  logic [LEN_REGNO-1:0]   f_rs;
  logic [LEN_CC-1:0]      f_cc;
  logic [15:0]            f_imm;
  logic [LEN_IMM_EX-1:0]  f_imm_ex;
  logic [LEN_REG-1:0]     fwd_rd;
  logic [LEN_REG-1:0]     fwd_rs;
  logic                   is_exec;
  logic                   is_hlt;
  logic                   is_legal;
  logic                   writes_rd;
  logic                   accept;
  logic                   issue;
  logic                   hold;

  assign f_op   = if_insn[31:25];
  assign f_immf = if_insn[24];
  assign f_rd   = if_insn[23:20];
  assign f_rs   = if_insn[19:16];
  assign f_cc   = if_insn[15:12];
  assign f_imm  = if_insn[15:0];

  always_comb begin
    // Every encoding from add (0000000) through ja (0011011) is a real instruction.
    is_exec   = (f_op <= OP_JA);
    is_hlt    = (f_op == OP_HLT);
    is_legal  = is_exec || is_hlt || (f_op == OP_NOP);
    writes_rd = is_exec && (f_op != OP_CMP) && (f_op != OP_ST) &&
                (f_op != OP_J) && (f_op != OP_JA);
    if (f_op[6:3] == 4'b0010)
      f_imm_ex = {{(LEN_IMM_EX-16){1'b0}}, f_imm};
    else
      f_imm_ex = {{(LEN_IMM_EX-16){f_imm[15]}}, f_imm};
  end

  assign fwd_rd = (wb_we && wb_addr == f_rd) ? wb_data : regs[f_rd];
  assign fwd_rs = (wb_we && wb_addr == f_rs) ? wb_data : regs[f_rs];

  assign if_ready = (state == RUN) && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;
  assign issue    = accept && is_exec;
  assign hold     = ex_valid && !ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**LEN_REGNO; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      opecode    <= '0;
      immf       <= '0;
      data_rd    <= '0;
      data_rs    <= '0;
      cc         <= '0;
      imm_ex     <= '0;
      ex_rd_addr <= '0;
      ex_rs_addr <= '0;
      ex_wen     <= 1'b0;
    end else if (issue) begin
      ex_valid   <= 1'b1;
      opecode    <= f_op;
      immf       <= f_immf;
      data_rd    <= fwd_rd;
      data_rs    <= fwd_rs;
      cc         <= f_cc;
      imm_ex     <= f_imm_ex;
      ex_rd_addr <= f_rd;
      ex_rs_addr <= f_rs;
      ex_wen     <= writes_rd;
    end else if (hold) begin
      // A stalled bundle keeps its operands current with writeback.
      if (wb_we && wb_addr == ex_rd_addr) data_rd <= wb_data;
      if (wb_we && wb_addr == ex_rs_addr) data_rs <= wb_data;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (accept && !is_legal) illegal <= 1'b1;
      case (state)
        RUN: if (accept && is_hlt) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        HALT: if (resume) begin
          state  <= RUN;
          halted <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed vector bench for decode_issue: per-cycle stimulus with hand-computed bundle, flag and handshake values.
module tb_decode_issue;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_insn;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  opecode;
  logic [0:0]  immf;
  logic [31:0] data_rd;
  logic [31:0] data_rs;
  logic [3:0]  cc;
  logic [31:0] imm_ex;
  logic [3:0]  ex_rd_addr;
  logic        ex_wen;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        resume;
  logic        halted;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  decode_issue dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_insn(if_insn),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .opecode(opecode), .immf(immf), .data_rd(data_rd), .data_rs(data_rs),
    .cc(cc), .imm_ex(imm_ex), .ex_rd_addr(ex_rd_addr), .ex_wen(ex_wen),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .resume(resume), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] insn;
    logic        er;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        res;
    logic        rdy;   // if_ready during the cycle
    logic        vld;   // ex_valid after the edge
    logic        cb;    // compare bundle fields
    logic [6:0]  op;
    logic [31:0] drd;
    logic [31:0] drs;
    logic [31:0] imm;
    logic        wen;
    logic [3:0]  ra;
    logic [4:0]  ic;    // {immf, cc}
    logic        hlt;
    logic        ill;
  } vec_t;

  vec_t vecs [0:23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] insn, input logic er,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic res);
    if_valid = iv; if_insn = insn; ex_ready = er;
    wb_we = we; wb_addr = wa; wb_data = wd; resume = res;
  endtask

  initial begin
    // iv insn er we wa wd res | rdy vld cb op drd drs imm wen ra ic hlt ill
    vecs[0]  = '{0, 32'h0,        1, 1, 4'd3, 32'h11, 0, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 0};
    vecs[1]  = '{0, 32'h0,        1, 1, 4'd5, 32'h22, 0, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 0};
    vecs[2]  = '{1, 32'h00350000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h00, 32'h11, 32'h22, 32'h0,        1, 4'd3, 5'h00, 0, 0};
    vecs[3]  = '{1, 32'h23358001, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h11, 32'h11, 32'h22, 32'h00008001, 1, 4'd3, 5'h18, 0, 0};
    vecs[4]  = '{1, 32'h01358001, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h00, 32'h11, 32'h22, 32'hFFFF8001, 1, 4'd3, 5'h18, 0, 0};
    vecs[5]  = '{1, 32'h00530000, 0, 0, 4'd0, 32'h0,  0, 0, 1, 1, 7'h00, 32'h11, 32'h22, 32'hFFFF8001, 1, 4'd3, 5'h18, 0, 0};
    vecs[6]  = '{1, 32'h00530000, 0, 1, 4'd5, 32'h99, 0, 0, 1, 1, 7'h00, 32'h11, 32'h99, 32'hFFFF8001, 1, 4'd3, 5'h18, 0, 0};
    vecs[7]  = '{1, 32'h00530000, 0, 0, 4'd0, 32'h0,  0, 0, 1, 1, 7'h00, 32'h11, 32'h99, 32'hFFFF8001, 1, 4'd3, 5'h18, 0, 0};
    vecs[8]  = '{1, 32'h00530000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h00, 32'h99, 32'h11, 32'h0,        1, 4'd5, 5'h00, 0, 0};
    vecs[9]  = '{1, 32'h00350000, 1, 1, 4'd3, 32'h77, 0, 1, 1, 1, 7'h00, 32'h77, 32'h99, 32'h0,        1, 4'd3, 5'h00, 0, 0};
    vecs[10] = '{1, 32'hFE000000, 1, 0, 4'd0, 32'h0,  0, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 1, 0};
    vecs[11] = '{1, 32'h00350000, 1, 0, 4'd0, 32'h0,  0, 0, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 1, 0};
    vecs[12] = '{1, 32'h00350000, 1, 0, 4'd0, 32'h0,  1, 0, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 0};
    vecs[13] = '{1, 32'h00350000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h00, 32'h77, 32'h99, 32'h0,        1, 4'd3, 5'h00, 0, 0};
    vecs[14] = '{1, 32'h80000000, 1, 0, 4'd0, 32'h0,  0, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 1};
    vecs[15] = '{1, 32'hFC000000, 1, 0, 4'd0, 32'h0,  0, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 1};
    vecs[16] = '{1, 32'h32350000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h19, 32'h77, 32'h99, 32'h0,        0, 4'd3, 5'h00, 0, 1};
    vecs[17] = '{1, 32'h3035FFFF, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h18, 32'h77, 32'h99, 32'hFFFFFFFF, 1, 4'd3, 5'h0F, 0, 1};
    vecs[18] = '{1, 32'h08350000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h04, 32'h77, 32'h99, 32'h0,        0, 4'd3, 5'h00, 0, 1};
    vecs[19] = '{1, 32'h10350000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h08, 32'h77, 32'h99, 32'h0,        1, 4'd3, 5'h00, 0, 1};
    vecs[20] = '{0, 32'h0,        1, 0, 4'd0, 32'h0,  1, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 1};
    vecs[21] = '{1, 32'h00770000, 1, 0, 4'd0, 32'h0,  0, 1, 1, 1, 7'h00, 32'h0,  32'h0,  32'h0,        1, 4'd7, 5'h00, 0, 1};
    vecs[22] = '{0, 32'h0,        0, 1, 4'd7, 32'hAB, 0, 0, 1, 1, 7'h00, 32'hAB, 32'hAB, 32'h0,        1, 4'd7, 5'h00, 0, 1};
    vecs[23] = '{0, 32'h0,        1, 0, 4'd0, 32'h0,  0, 1, 0, 0, 7'h00, 32'h0,  32'h0,  32'h0,        0, 4'd0, 5'h00, 0, 1};

    rst_n = 1'b0;
    drive(0, 32'h0, 1, 0, 4'd0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("reset halted", {31'b0, halted}, 32'h0);
    chk("reset illegal", {31'b0, illegal}, 32'h0);
    chk("reset if_ready", {31'b0, if_ready}, 32'h1);
    chk("reset opecode", {25'b0, opecode}, 32'h0);
    chk("reset data_rd", data_rd, 32'h0);
    chk("reset imm_ex", imm_ex, 32'h0);
    chk("reset ex_wen", {31'b0, ex_wen}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].insn, vecs[i].er, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].res);
      #1;
      chk($sformatf("v%0d if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].vld});
      chk($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].hlt});
      chk($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
      if (vecs[i].cb) begin
        chk($sformatf("v%0d opecode", i), {25'b0, opecode}, {25'b0, vecs[i].op});
        chk($sformatf("v%0d data_rd", i), data_rd, vecs[i].drd);
        chk($sformatf("v%0d data_rs", i), data_rs, vecs[i].drs);
        chk($sformatf("v%0d imm_ex", i), imm_ex, vecs[i].imm);
        chk($sformatf("v%0d ex_wen", i), {31'b0, ex_wen}, {31'b0, vecs[i].wen});
        chk($sformatf("v%0d ex_rd_addr", i), {28'b0, ex_rd_addr}, {28'b0, vecs[i].ra});
        chk($sformatf("v%0d immf_cc", i), {27'b0, immf, cc}, {27'b0, vecs[i].ic});
      end
    end

    // Reset mid-stream with a held bundle and sticky illegal; resume held high must not matter.
    @(negedge clk);
    drive(1, 32'h00350000, 0, 0, 4'd0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("pre-reset ex_valid", {31'b0, ex_valid}, 32'h1);
    chk("pre-reset data_rd", data_rd, 32'h77);
    #2;
    rst_n = 1'b0;
    resume = 1'b1;
    #1;
    chk("async reset ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("async reset illegal", {31'b0, illegal}, 32'h0);
    chk("async reset data_rd", data_rd, 32'h0);
    chk("async reset halted", {31'b0, halted}, 32'h0);
    @(posedge clk);
    #1;
    chk("reset hold ex_valid", {31'b0, ex_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h00350000, 1, 0, 4'd0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("post-reset ex_valid", {31'b0, ex_valid}, 32'h1);
    chk("post-reset r3 cleared", data_rd, 32'h0);
    chk("post-reset r5 cleared", data_rs, 32'h0);
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 4'd0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
